multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the CPU31 datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, and turns the 54-bit one-hot instruction-decode vector into per-cycle datapath strobes. It handles a shared memory handshake, counts retired instructions, and traps on illegal decodes.

## Interface
- DECODE_W, 54: width of the one-hot decode vector.
- CNT_W, 32: width of the retired-instruction counter.

- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- RUN  in  1  start/continue enable, sampled at IDLE and at retire points.
- DECODE  in  DECODE_W  one-hot decode of the current IR.
  - Bit map: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT, 9 SLTU, 10 SLL, 11 SRL, 12 SRA, 13 SLLV, 14 SRLV, 15 SRAV, 16 JR, 17 ADDI, 18 ADDIU, 19 ANDI, 20 ORI, 21 XORI, 22 LW, 23 SW, 24 BEQ, 25 BNE, 26 SLTI, 27 SLTIU, 28 LUI, 29 J, 30 JAL.
  - Bits 31..53 are reserved.
- ZERO  in  1  ALU zero flag.
- MEM_ACK  in  1  memory ready; completes the current IM_RE/DM_RE/DM_WE request.
- IM_RE  out  1  instruction fetch request.
- IR_WE  out  1  IR load strobe.
- PC_WE  out  1  PC write strobe.
- PC_SEL  out  2  PC source: 0 PC+4, 1 branch target, 2 jump {HEAD,INDEX,00}, 3 rs.
- RF_WE  out  1  register-file write strobe.
- WB_SEL  out  2  write-back source: 0 ALU, 1 data memory, 2 PC (link).
- DM_RE  out  1  data memory read request.
- DM_WE  out  1  data memory write request.
- ALU_OP  out  4  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI.
- ALUA_SEL  out  1  ALU A source: 0 rs, 1 SA.
- ALUB_SEL  out  1  ALU B source: 0 rt, 1 extended immediate.
- EXT_SIGNED  out  1  immediate extension: 1 sign, 0 zero.
- STATE  out  3  current FSM state.
- ILLEGAL  out  1  sticky trap flag.
- INSTR_CNT  out  CNT_W  retired-instruction count.

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6. Encoding 7 is unreachable and recovers to IDLE on the next edge.
- STATE, ILLEGAL and INSTR_CNT are registered. All other outputs are combinational decodes of STATE and DECODE, and are 0 in IDLE and TRAP.
- IDLE: RUN=1 -> FETCH; otherwise stay.
- FETCH: IM_RE=1 until MEM_ACK. On the ack cycle: IR_WE=1, PC_WE=1, PC_SEL=0, then -> DECODE.
- DECODE: legal means exactly one of bits 0..30 is set and bits 31..53 are all 0.
  - Legal -> EXEC.
  - Illegal -> TRAP and set ILLEGAL.
- EXEC, by instruction class:
  - Arithmetic, logic, shift, SLTI/SLTIU, LUI: drive ALU_OP/ALUA_SEL/ALUB_SEL/EXT_SIGNED -> WB.
    - ADDU/ADDIU map to ADD; SUBU maps to SUB; SLTIU maps to SLTU.
    - ALUA_SEL=1 only for SLL/SRL/SRA.
    - ALUB_SEL=1 for all I-type.
    - EXT_SIGNED=1 for ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ, BNE; 0 for ANDI, ORI, XORI, LUI.
  - LW/SW: ALU_OP=ADD, ALUB_SEL=1 -> MEM.
  - BEQ/BNE: ALU_OP=SUB, PC_SEL=1. PC_WE = ZERO for BEQ, ~ZERO for BNE. Retire.
  - J: PC_SEL=2, PC_WE=1. Retire.
  - JAL: as J, plus RF_WE=1, WB_SEL=2. Retire.
  - JR: PC_SEL=3, PC_WE=1. Retire.
- MEM:
  - LW: DM_RE=1 until MEM_ACK -> WB with WB_SEL=1.
  - SW: DM_WE=1 until MEM_ACK; retire.
  - ALU_OP and ALUB_SEL are held throughout MEM.
- WB: RF_WE=1 for exactly one cycle (WB_SEL=0 for ALU results, 1 for LW); retire.
- Retire: INSTR_CNT increments by 1 and wraps modulo 2^CNT_W. Next state is FETCH if RUN=1, else IDLE.
- RUN=0 mid-instruction: the instruction completes; the FSM stops only at retire.
- TRAP is sticky; only RST leaves it.
- MEM_ACK outside FETCH/MEM is ignored.

## Timing
- Reset: on an edge with RST=1, STATE=IDLE, ILLEGAL=0, INSTR_CNT=0. RST has priority over every other input.
- All strobes are 0 from the first cycle after the reset edge.
- During the RST-high cycle itself, outputs still reflect the pre-reset state.
- Reset during MEM drops DM_WE/DM_RE after that edge. No retire is counted.
- Cycles per instruction with MEM_ACK high on the request cycle:
  - ALU/I-type: 4 (FETCH, DECODE, EXEC, WB).
  - Branch/jump: 3.
  - LW: 5.
  - SW: 4.
- Each wait cycle on MEM_ACK adds one cycle. Requests stay asserted and stable while waiting.
- PC_WE in FETCH precedes the EXEC branch/jump write, so the branch target is computed from PC+4.
- INSTR_CNT updates on the edge that leaves the retire state.

## Test plan
- RST high 2 cycles, RUN=0 -> STATE=0, ILLEGAL=0, INSTR_CNT=0, all strobes 0; stays IDLE for 10 cycles.
- RUN=1, DECODE=bit0 (ADD), MEM_ACK=1 -> states 1,2,3,5,1.
  - RF_WE single pulse in WB with WB_SEL=0, ALU_OP=0.
  - INSTR_CNT=1 after 4 cycles.
- LW with MEM_ACK low 3 cycles in MEM -> DM_RE held high 4 cycles, then WB with WB_SEL=1. Total 8 cycles.
- BNE: ZERO=1 -> PC_WE=0 in EXEC. ZERO=0 -> PC_WE=1, PC_SEL=1. Both retire in 3 cycles.
- JAL -> EXEC drives PC_SEL=2, PC_WE=1, RF_WE=1, WB_SEL=2 in the same cycle.
- Illegal decodes:
  - DECODE=bits 0 and 5 -> TRAP, ILLEGAL=1 persisting with RUN=1.
  - DECODE=bit 40 alone -> TRAP.
  - RST -> IDLE, ILLEGAL=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the CPU31 datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// decodes the one-hot instruction vector into datapath strobes, counts retirements, traps on illegal decodes.
module multicycle_ctrl #(
    parameter int DECODE_W = 54,
    parameter int CNT_W    = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RUN,
    input  logic [DECODE_W-1:0] DECODE,
    input  logic                ZERO,
    input  logic                MEM_ACK,
    output logic                IM_RE,
    output logic                IR_WE,
    output logic                PC_WE,
    output logic [1:0]          PC_SEL,
    output logic                RF_WE,
    output logic [1:0]          WB_SEL,
    output logic                DM_RE,
    output logic                DM_WE,
    output logic [3:0]          ALU_OP,
    output logic                ALUA_SEL,
    output logic                ALUB_SEL,
    output logic                EXT_SIGNED,
    output logic [2:0]          STATE,
    output logic                ILLEGAL,
    output logic [CNT_W-1:0]    INSTR_CNT
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam int B_JR  = 16;
    localparam int B_LW  = 22;
    localparam int B_SW  = 23;
    localparam int B_BEQ = 24;
    localparam int B_BNE = 25;
    localparam int B_J   = 29;
    localparam int B_JAL = 30;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] PC_SEQ  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JMP  = 2'd2;
    localparam logic [1:0] PC_RS   = 2'd3;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic decode_legal(input logic [DECODE_W-1:0] dec);
        logic [5:0] ones;
        ones = 6'd0;
        for (int i = 0; i < 31; i++) begin
            ones = ones + {5'd0, dec[i]};
        end
        return (ones == 6'd1) && (dec[DECODE_W-1:31] == '0);
    endfunction

    function automatic logic [3:0] alu_op_of(input logic [DECODE_W-1:0] dec);
        logic [3:0] op;
        if (dec[2] | dec[3] | dec[B_BEQ] | dec[B_BNE]) begin
            op = ALU_SUB;
        end else if (dec[4] | dec[19]) begin
            op = ALU_AND;
        end else if (dec[5] | dec[20]) begin
            op = ALU_OR;
        end else if (dec[6] | dec[21]) begin
            op = ALU_XOR;
        end else if (dec[7]) begin
            op = ALU_NOR;
        end else if (dec[8] | dec[26]) begin
            op = ALU_SLT;
        end else if (dec[9] | dec[27]) begin
            op = ALU_SLTU;
        end else if (dec[10] | dec[13]) begin
            op = ALU_SLL;
        end else if (dec[11] | dec[14]) begin
            op = ALU_SRL;
        end else if (dec[12] | dec[15]) begin
            op = ALU_SRA;
        end else if (dec[28]) begin
            op = ALU_LUI;
        end else begin
            op = ALU_ADD;
        end
        return op;
    endfunction

    function automatic logic alua_of(input logic [DECODE_W-1:0] dec);
        return dec[10] | dec[11] | dec[12];
    endfunction

    function automatic logic alub_of(input logic [DECODE_W-1:0] dec);
        return (|dec[B_SW:17]) | dec[26] | dec[27] | dec[28];
    endfunction

    function automatic logic ext_of(input logic [DECODE_W-1:0] dec);
        return dec[17] | dec[18] | dec[B_LW] | dec[B_SW] | dec[B_BEQ] | dec[B_BNE]
             | dec[26] | dec[27];
    endfunction

    logic [2:0]       r_state;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instr_cnt;

    logic [2:0]       w_next_state;
    logic [2:0]       w_retire_target;
    logic             w_legal;
    logic             w_is_mem;
    logic             w_is_ctl;
    logic             w_retire;

    logic             w_im_re;
    logic             w_ir_we;
    logic             w_pc_we;
    logic [1:0]       w_pc_sel;
    logic             w_rf_we;
    logic [1:0]       w_wb_sel;
    logic             w_dm_re;
    logic             w_dm_we;
    logic [3:0]       w_alu_op;
    logic             w_alua_sel;
    logic             w_alub_sel;
    logic             w_ext_signed;

    assign w_legal         = decode_legal(DECODE);
    assign w_is_mem        = DECODE[B_LW] | DECODE[B_SW];
    assign w_is_ctl        = DECODE[B_JR] | DECODE[B_BEQ] | DECODE[B_BNE] | DECODE[B_J] | DECODE[B_JAL];
    assign w_retire_target = RUN ? S_FETCH : S_IDLE;

    // Retire points: control transfers in EXEC, stores on their ack, everything else in WB.
    assign w_retire = ((r_state == S_EXEC) && w_is_ctl && !w_is_mem)
                   || ((r_state == S_MEM) && MEM_ACK && !DECODE[B_LW])
                   ||  (r_state == S_WB);

    // State, trap flag and retirement counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_illegal   <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_DECODE) && !w_legal) begin
                r_illegal <= 1'b1;
            end else begin
                r_illegal <= r_illegal;
            end
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + CNT_ONE;
            end else begin
                r_instr_cnt <= r_instr_cnt;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (RUN) w_next_state = S_FETCH;
                else     w_next_state = S_IDLE;
            end
            S_FETCH: begin
                if (MEM_ACK) w_next_state = S_DECODE;
                else         w_next_state = S_FETCH;
            end
            S_DECODE: begin
                if (w_legal) w_next_state = S_EXEC;
                else         w_next_state = S_TRAP;
            end
            S_EXEC: begin
                if (w_is_mem)      w_next_state = S_MEM;
                else if (w_is_ctl) w_next_state = w_retire_target;
                else               w_next_state = S_WB;
            end
            S_MEM: begin
                if (!MEM_ACK)          w_next_state = S_MEM;
                else if (DECODE[B_LW]) w_next_state = S_WB;
                else                   w_next_state = w_retire_target;
            end
            S_WB:    w_next_state = w_retire_target;
            S_TRAP:  w_next_state = S_TRAP;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state and instruction.
    always_comb begin
        w_im_re      = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_sel     = PC_SEQ;
        w_rf_we      = 1'b0;
        w_wb_sel     = WB_ALU;
        w_dm_re      = 1'b0;
        w_dm_we      = 1'b0;
        w_alu_op     = ALU_ADD;
        w_alua_sel   = 1'b0;
        w_alub_sel   = 1'b0;
        w_ext_signed = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_im_re = 1'b1;
                if (MEM_ACK) begin
                    w_ir_we  = 1'b1;
                    w_pc_we  = 1'b1;
                    w_pc_sel = PC_SEQ;
                end else begin
                    w_ir_we  = 1'b0;
                    w_pc_we  = 1'b0;
                end
            end
            S_EXEC: begin
                w_alu_op     = alu_op_of(DECODE);
                w_alua_sel   = alua_of(DECODE);
                w_alub_sel   = alub_of(DECODE);
                w_ext_signed = ext_of(DECODE);
                if (DECODE[B_BEQ] | DECODE[B_BNE]) begin
                    w_pc_sel = PC_BR;
                    w_pc_we  = DECODE[B_BEQ] ? ZERO : ~ZERO;
                end else if (DECODE[B_J] | DECODE[B_JAL]) begin
                    w_pc_sel = PC_JMP;
                    w_pc_we  = 1'b1;
                    w_rf_we  = DECODE[B_JAL];
                    w_wb_sel = DECODE[B_JAL] ? WB_LINK : WB_ALU;
                end else if (DECODE[B_JR]) begin
                    w_pc_sel = PC_RS;
                    w_pc_we  = 1'b1;
                end else begin
                    w_pc_we  = 1'b0;
                end
            end
            S_MEM: begin
                // ALU keeps producing the effective address while the request is pending.
                w_alu_op     = alu_op_of(DECODE);
                w_alub_sel   = alub_of(DECODE);
                w_ext_signed = ext_of(DECODE);
                w_dm_re      = DECODE[B_LW];
                w_dm_we      = DECODE[B_SW];
            end
            S_WB: begin
                w_alu_op     = alu_op_of(DECODE);
                w_alua_sel   = alua_of(DECODE);
                w_alub_sel   = alub_of(DECODE);
                w_ext_signed = ext_of(DECODE);
                w_rf_we      = 1'b1;
                w_wb_sel     = DECODE[B_LW] ? WB_MEM : WB_ALU;
            end
            default: begin
                w_im_re = 1'b0;
            end
        endcase
    end

    assign IM_RE      = w_im_re;
    assign IR_WE      = w_ir_we;
    assign PC_WE      = w_pc_we;
    assign PC_SEL     = w_pc_sel;
    assign RF_WE      = w_rf_we;
    assign WB_SEL     = w_wb_sel;
    assign DM_RE      = w_dm_re;
    assign DM_WE      = w_dm_we;
    assign ALU_OP     = w_alu_op;
    assign ALUA_SEL   = w_alua_sel;
    assign ALUB_SEL   = w_alub_sel;
    assign EXT_SIGNED = w_ext_signed;
    assign STATE      = r_state;
    assign ILLEGAL    = r_illegal;
    assign INSTR_CNT  = r_instr_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a randomized
// instruction stream checked against an opcode-table reference model.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic [53:0] decode;
    logic        zero;
    logic        mem_ack;
    logic        im_re, ir_we, pc_we, rf_we, dm_re, dm_we;
    logic        alua_sel, alub_sel, ext_signed, illegal;
    logic [1:0]  pc_sel, wb_sel;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    int checks;
    int failures;

    multicycle_ctrl #(.DECODE_W(54), .CNT_W(32)) dut (
        .CLK(clk), .RST(rst), .RUN(run), .DECODE(decode), .ZERO(zero), .MEM_ACK(mem_ack),
        .IM_RE(im_re), .IR_WE(ir_we), .PC_WE(pc_we), .PC_SEL(pc_sel), .RF_WE(rf_we),
        .WB_SEL(wb_sel), .DM_RE(dm_re), .DM_WE(dm_we), .ALU_OP(alu_op), .ALUA_SEL(alua_sel),
        .ALUB_SEL(alub_sel), .EXT_SIGNED(ext_signed), .STATE(state), .ILLEGAL(illegal),
        .INSTR_CNT(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU operation per opcode bit number.
    function automatic int ref_alu(input int k);
        case (k)
            0, 1, 17, 18, 22, 23: return 0;
            2, 3, 24, 25:         return 1;
            4, 19:                return 2;
            5, 20:                return 3;
            6, 21:                return 4;
            7:                    return 5;
            8, 26:                return 6;
            9, 27:                return 7;
            10, 13:               return 8;
            11, 14:               return 9;
            12, 15:               return 10;
            28:                   return 11;
            default:              return 0;
        endcase
    endfunction

    // Expected {state, strobes} for instruction k while in state st.
    function automatic logic [19:0] exp_vec(input int st, input int k, input bit ack, input bit z);
        bit im, ir, pcwe, rfwe, dmre, dmwe, alua, alub, ext;
        int pcsel, wbsel, aop;
        im = 0; ir = 0; pcwe = 0; rfwe = 0; dmre = 0; dmwe = 0; alua = 0; alub = 0; ext = 0;
        pcsel = 0; wbsel = 0; aop = 0;
        if (st >= 3 && st <= 5) begin
            aop  = ref_alu(k);
            alua = (k >= 10 && k <= 12);
            alub = (k >= 17 && k <= 23) || (k >= 26 && k <= 28);
            ext  = (k inside {17, 18, 22, 23, 24, 25, 26, 27});
            if (st == 4) alua = 0;
        end
        case (st)
            1: begin im = 1; ir = ack; pcwe = ack; end
            3: begin
                case (k)
                    16: begin pcsel = 3; pcwe = 1; end
                    24: begin pcsel = 1; pcwe = z; end
                    25: begin pcsel = 1; pcwe = !z; end
                    29: begin pcsel = 2; pcwe = 1; end
                    30: begin pcsel = 2; pcwe = 1; rfwe = 1; wbsel = 2; end
                    default: ;
                endcase
            end
            4: begin dmre = (k == 22); dmwe = (k == 23); end
            5: begin rfwe = 1; wbsel = (k == 22) ? 1 : 0; end
            default: ;
        endcase
        return {st[2:0], im, ir, pcwe, pcsel[1:0], rfwe, wbsel[1:0], dmre, dmwe, aop[3:0], alua, alub, ext};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {state, im_re, ir_we, pc_we, pc_sel, rf_we, wb_sel, dm_re, dm_we, alu_op,
                alua_sel, alub_sel, ext_signed};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; decode = '0; zero = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Reset, then one IDLE cycle with RUN=1 so the FSM is in FETCH.
    task automatic start(input int k);
        do_reset();
        decode = '0;
        decode[k] = 1'b1;
        run = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || illegal !== 1'b0 || instr_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs state=%0d ill=%0b cnt=%0d required 0/0/0", state, illegal, instr_cnt);
        end
        checks++;
        if (obs_vec() !== 20'd0) begin
            failures++;
            $display("FAIL reset_strobes got=%h required 0", obs_vec());
        end
        step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd0) begin
                failures++;
                $display("FAIL idle_hold cycle=%0d state=%0d required 0", i, state);
            end
            step();
        end
    endtask

    task automatic test_add();
        int es[4] = '{1, 2, 3, 5};
        start(0);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (state !== es[i][2:0] || rf_we !== (i == 3)) begin
                failures++;
                $display("FAIL add_seq cycle=%0d state=%0d rf_we=%0b required %0d/%0b", i, state, rf_we, es[i], i == 3);
            end
            if (i == 3) begin
                checks++;
                if (wb_sel !== 2'd0 || alu_op !== 4'd0) begin
                    failures++;
                    $display("FAIL add_wb wb_sel=%0d alu_op=%0d required 0/0", wb_sel, alu_op);
                end
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd1 || instr_cnt !== 32'd1) begin
            failures++;
            $display("FAIL add_retire state=%0d cnt=%0d required 1/1", state, instr_cnt);
        end
    endtask

    task automatic test_lw_wait();
        int es[8] = '{1, 2, 3, 4, 4, 4, 4, 5};
        start(22);
        for (int i = 0; i < 8; i++) begin
            mem_ack = (i == 0 || i == 6);
            @(negedge clk);
            checks++;
            if (state !== es[i][2:0] || dm_re !== (i >= 3 && i <= 6)) begin
                failures++;
                $display("FAIL lw_seq cycle=%0d state=%0d dm_re=%0b required %0d/%0b", i, state, dm_re, es[i], i >= 3 && i <= 6);
            end
            if (i == 7) begin
                checks++;
                if (rf_we !== 1'b1 || wb_sel !== 2'd1) begin
                    failures++;
                    $display("FAIL lw_wb rf_we=%0b wb_sel=%0d required 1/1", rf_we, wb_sel);
                end
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd1 || instr_cnt !== 32'd1) begin
            failures++;
            $display("FAIL lw_retire state=%0d cnt=%0d required 1/1", state, instr_cnt);
        end
    endtask

    task automatic test_bne();
        for (int zi = 0; zi < 2; zi++) begin
            start(25);
            zero = (zi == 0);
            mem_ack = 1'b1;
            step();
            step();
            @(negedge clk);
            checks++;
            if (state !== 3'd3 || pc_sel !== 2'd1 || pc_we !== (zi == 1)) begin
                failures++;
                $display("FAIL bne_exec zero=%0b state=%0d pc_sel=%0d pc_we=%0b required 3/1/%0b", zero, state, pc_sel, pc_we, zi == 1);
            end
            step();
            @(negedge clk);
            checks++;
            if (state !== 3'd1 || instr_cnt !== 32'd1) begin
                failures++;
                $display("FAIL bne_retire state=%0d cnt=%0d required 1/1", state, instr_cnt);
            end
        end
    endtask

    task automatic test_jal();
        start(30);
        mem_ack = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({state, pc_sel, pc_we, rf_we, wb_sel} !== {3'd3, 2'd2, 1'b1, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL jal_exec state=%0d pc_sel=%0d pc_we=%0b rf_we=%0b wb_sel=%0d required 3/2/1/1/2",
                     state, pc_sel, pc_we, rf_we, wb_sel);
        end
    endtask

    task automatic test_illegal();
        for (int c = 0; c < 2; c++) begin
            start(0);
            if (c == 0) decode[5] = 1'b1;
            else begin decode = '0; decode[40] = 1'b1; end
            mem_ack = 1'b1;
            step();
            step();
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                checks++;
                if (state !== 3'd6 || illegal !== 1'b1 || obs_vec()[16:0] !== 17'd0) begin
                    failures++;
                    $display("FAIL trap_hold case=%0d cycle=%0d state=%0d ill=%0b required 6/1", c, i, state, illegal);
                end
                step();
            end
            rst = 1'b1;
            step();
            rst = 1'b0;
            run = 1'b0;
            @(negedge clk);
            checks++;
            if (state !== 3'd0 || illegal !== 1'b0) begin
                failures++;
                $display("FAIL trap_reset state=%0d ill=%0b required 0/0", state, illegal);
            end
        end
    endtask

    task automatic test_reset_in_mem();
        start(23);
        mem_ack = 1'b1;
        step();
        step();
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd4 || dm_we !== 1'b1) begin
            failures++;
            $display("FAIL sw_mem state=%0d dm_we=%0b required 4/1", state, dm_we);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dm_we !== 1'b1) begin
            failures++;
            $display("FAIL rst_cycle_hold dm_we=%0b required 1", dm_we);
        end
        step();
        rst = 1'b0;
        run = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || dm_we !== 1'b0 || instr_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rst_in_mem state=%0d dm_we=%0b cnt=%0d required 0/0/0", state, dm_we, instr_cnt);
        end
    endtask

    task automatic test_random();
        int sq[$];
        bit aq[$];
        int m_cnt;
        int k, fw, mw;
        bit last;
        do_reset();
        run = 1'b1;
        step();
        m_cnt = 0;
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(30, 0);
            fw = $urandom_range(2, 0);
            mw = $urandom_range(3, 0);
            last = (n == 149);
            sq.delete();
            aq.delete();
            repeat (fw) begin sq.push_back(1); aq.push_back(1'b0); end
            sq.push_back(1); aq.push_back(1'b1);
            sq.push_back(2); aq.push_back(1'($urandom_range(1, 0)));
            sq.push_back(3); aq.push_back(1'($urandom_range(1, 0)));
            if (k == 22 || k == 23) begin
                repeat (mw) begin sq.push_back(4); aq.push_back(1'b0); end
                sq.push_back(4); aq.push_back(1'b1);
            end
            if (k <= 15 || (k >= 17 && k <= 22) || (k >= 26 && k <= 28)) begin
                sq.push_back(5); aq.push_back(1'($urandom_range(1, 0)));
            end
            decode = '0;
            decode[k] = 1'b1;
            for (int i = 0; i < sq.size(); i++) begin
                mem_ack = aq[i];
                zero = 1'($urandom_range(1, 0));
                if (i == sq.size() - 1) run = !last;
                else run = 1'($urandom_range(1, 0));
                @(negedge clk);
                checks++;
                if (obs_vec() !== exp_vec(sq[i], k, aq[i], zero) || instr_cnt !== m_cnt) begin
                    failures++;
                    $display("FAIL rand_cycle n=%0d op=%0d i=%0d got=%h cnt=%0d required %h cnt=%0d",
                             n, k, i, obs_vec(), instr_cnt, exp_vec(sq[i], k, aq[i], zero), m_cnt);
                end
                step();
            end
            m_cnt++;
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || instr_cnt !== m_cnt || illegal !== 1'b0) begin
            failures++;
            $display("FAIL rand_end state=%0d cnt=%0d ill=%0b required 0/%0d/0", state, instr_cnt, illegal, m_cnt);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; run = 1'b0; decode = '0; zero = 1'b0; mem_ack = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_bne();
        test_jal();
        test_illegal();
        test_reset_in_mem();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

endmodule
